// File: rtl/tt_rng_pkg.sv
// Shared types and default health-test thresholds for the TRNG health/packer block.
package tt_rng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STARTUP = 2'd1,
    RUN     = 2'd2,
    FAIL    = 2'd3
  } rng_state_t;

  localparam int unsigned RCT_CUTOFF_DEF = 32;
  localparam int unsigned APT_WINDOW_DEF = 1024;
  localparam int unsigned APT_CUTOFF_DEF = 840;
  localparam int unsigned START_BITS_DEF = 1024;

endpackage

// File: rtl/tt_rng_health_packer_if.sv
// Bit-stream input and packed-byte valid/ready output of the health packer.
interface tt_rng_health_packer_if;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output bit_in, bit_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/tt_rng_health_test.sv
// Repetition count and adaptive proportion tests; hits flag the bit being accepted.
module tt_rng_health_test
  import tt_rng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic bit_in,
  input  logic bit_accept,
  output logic rct_hit,
  output logic apt_hit
);

  localparam int unsigned RunW = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned AptW = $clog2(APT_WINDOW + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(RCT_CUTOFF);
  localparam logic [AptW-1:0] WinMax = AptW'(APT_WINDOW);
  localparam logic [AptW-1:0] AptCut = AptW'(APT_CUTOFF);

  logic [RunW-1:0] r_run, w_run_nxt;
  logic            r_prev;
  logic [AptW-1:0] r_win, w_win_nxt, r_match, w_match_nxt;
  logic            r_ref, w_ref_nxt;

  always_comb begin
    w_run_nxt = r_run;
    if (r_run == '0 || bit_in != r_prev) begin
      w_run_nxt = RunW'(1);
    end else if (r_run != RunMax) begin
      w_run_nxt = r_run + RunW'(1);
    end

    w_win_nxt   = r_win;
    w_match_nxt = r_match;
    w_ref_nxt   = r_ref;
    // A zero or full window count means this bit is the reference of a fresh window.
    if (r_win == '0 || r_win == WinMax) begin
      w_win_nxt   = AptW'(1);
      w_match_nxt = AptW'(1);
      w_ref_nxt   = bit_in;
    end else begin
      w_win_nxt = r_win + AptW'(1);
      if (bit_in == r_ref && r_match != WinMax) begin
        w_match_nxt = r_match + AptW'(1);
      end
    end

    rct_hit = bit_accept && (w_run_nxt >= RunMax);
    apt_hit = bit_accept && (w_match_nxt >= AptCut);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= '0;
      r_prev  <= 1'b0;
      r_win   <= '0;
      r_match <= '0;
      r_ref   <= 1'b0;
    end else if (restart) begin
      r_run   <= '0;
      r_prev  <= 1'b0;
      r_win   <= '0;
      r_match <= '0;
      r_ref   <= 1'b0;
    end else if (bit_accept) begin
      r_run   <= w_run_nxt;
      r_prev  <= bit_in;
      r_win   <= w_win_nxt;
      r_match <= w_match_nxt;
      r_ref   <= w_ref_nxt;
    end
  end

endmodule

// File: rtl/tt_rng_health_packer.sv
// Health-gated TRNG byte packer: start-up qualification, MSB-first packing, sticky faults.
module tt_rng_health_packer
  import tt_rng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int unsigned APT_WINDOW = APT_WINDOW_DEF,
  parameter int unsigned APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int unsigned START_BITS = START_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clr_fail,
  tt_rng_health_packer_if.slave        bus,
  output logic                         online,
  output logic                         rct_fail,
  output logic                         apt_fail,
  output logic                         overrun
);

  localparam int unsigned StW = $clog2(START_BITS + 1);
  localparam logic [StW-1:0] StMax = StW'(START_BITS);

  rng_state_t     r_state, w_state_nxt;
  logic [StW-1:0] r_start_cnt, w_start_nxt;
  logic [6:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_out_data;
  logic           r_out_valid, r_rct_fail, r_apt_fail, r_overrun;
  logic           w_accept, w_restart, w_rct_hit, w_apt_hit, w_hit;
  logic           w_pack, w_byte_done, w_start_done, w_flush;

  assign w_accept  = enable && bus.bit_valid && (r_state == STARTUP || r_state == RUN);
  assign w_restart = !enable || (r_state == IDLE) || (r_state == FAIL && clr_fail);
  assign w_hit     = w_rct_hit || w_apt_hit;
  assign w_pack    = w_accept && (r_state == RUN) && !w_hit;
  assign w_byte_done = w_pack && (r_bit_cnt == 3'd7);
  // The failing bit is never packed; failure, FAIL and IDLE all flush the datapath.
  assign w_flush   = !enable || w_hit || (r_state == FAIL) || (r_state == IDLE);
  assign w_start_nxt  = (r_start_cnt == StMax) ? r_start_cnt : r_start_cnt + StW'(1);
  assign w_start_done = w_accept && (r_state == STARTUP) && (w_start_nxt == StMax);

  tt_rng_health_test #(
    .RCT_CUTOFF(RCT_CUTOFF),
    .APT_WINDOW(APT_WINDOW),
    .APT_CUTOFF(APT_CUTOFF)
  ) u_health (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (w_restart),
    .bit_in    (bus.bit_in),
    .bit_accept(w_accept),
    .rct_hit   (w_rct_hit),
    .apt_hit   (w_apt_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = STARTUP;
        STARTUP: begin
          if (w_hit)             w_state_nxt = FAIL;
          else if (w_start_done) w_state_nxt = RUN;
        end
        RUN:     if (w_hit) w_state_nxt = FAIL;
        FAIL:    if (clr_fail) w_state_nxt = STARTUP;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_start_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_start_cnt <= '0;
      end else if (w_accept && r_state == STARTUP) begin
        r_start_cnt <= w_start_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_flush) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_pack) begin
        r_shift   <= {r_shift[5:0], bus.bit_in};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_byte_done && (!r_out_valid || bus.out_ready)) begin
        r_out_data  <= {r_shift, bus.bit_in};
        r_out_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rct_fail <= 1'b0;
      r_apt_fail <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == FAIL && clr_fail) begin
        r_rct_fail <= 1'b0;
        r_apt_fail <= 1'b0;
      end else begin
        if (w_rct_hit) r_rct_fail <= 1'b1;
        if (w_apt_hit) r_apt_fail <= 1'b1;
      end
      if (w_byte_done && r_out_valid && !bus.out_ready) begin
        r_overrun <= 1'b1;
      end else if (clr_fail) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign online        = (r_state == RUN);
  assign rct_fail      = r_rct_fail;
  assign apt_fail      = r_apt_fail;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_tt_rng_health_packer.sv
// Directed bench for tt_rng_health_packer with hand-computed expectations.
module tb_tt_rng_health_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clr_fail = 1'b0;
  logic online, rct_fail, apt_fail, overrun;
  int   n_checks = 0;
  int   n_errors = 0;

  tt_rng_health_packer_if bus_if ();

  tt_rng_health_packer u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .clr_fail(clr_fail),
    .bus     (bus_if),
    .online  (online),
    .rct_fail(rct_fail),
    .apt_fail(apt_fail),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bit per clock: driven on the falling edge, outputs sampled 1ns after the rising edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    bus_if.bit_in    = b;
    bus_if.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_alt(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0]);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic set_enable(input logic v);
    @(negedge clk);
    enable = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_fail = 1'b1;
    @(posedge clk);
    #1;
    clr_fail = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    bus_if.bit_in    = 1'b0;
    bus_if.bit_valid = 1'b0;
    bus_if.out_ready = 1'b0;
    #12 rst_n = 1'b1;

    check("rst_data", {24'd0, bus_if.out_data}, 32'h00);
    check("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_online", {31'd0, online}, 32'd0);
    check("rst_flags", {29'd0, rct_fail, apt_fail, overrun}, 32'd0);

    // Start-up then packing
    set_enable(1'b1);
    send_alt(1023);
    check("startup_1023_online", {31'd0, online}, 32'd0);
    send_bit(1'b1);
    check("startup_1024_online", {31'd0, online}, 32'd1);
    check("startup_valid", {31'd0, bus_if.out_valid}, 32'd0);
    bus_if.out_ready = 1'b1;
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    check("a5_bit7_valid", {31'd0, bus_if.out_valid}, 32'd0);
    send_bit(v[0]);
    check("a5_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check("a5_data", {24'd0, bus_if.out_data}, 32'hA5);
    idle_cycle();
    check("a5_valid_drop", {31'd0, bus_if.out_valid}, 32'd0);

    // Backpressure: first byte held, second dropped
    bus_if.out_ready = 1'b0;
    send_byte(8'h3C);
    check("bp_first_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check("bp_first_data", {24'd0, bus_if.out_data}, 32'h3C);
    check("bp_first_overrun", {31'd0, overrun}, 32'd0);
    send_byte(8'h81);
    check("bp_held_data", {24'd0, bus_if.out_data}, 32'h3C);
    check("bp_held_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check("bp_overrun", {31'd0, overrun}, 32'd1);
    bus_if.out_ready = 1'b1;
    idle_cycle();
    check("bp_drain_valid", {31'd0, bus_if.out_valid}, 32'd0);
    pulse_clr();
    check("clr_outside_overrun", {31'd0, overrun}, 32'd0);
    check("clr_outside_online", {31'd0, online}, 32'd1);

    // Simultaneous load and drain
    bus_if.out_ready = 1'b0;
    send_byte(8'h55);
    check("sim_first_data", {24'd0, bus_if.out_data}, 32'h55);
    v = 8'hC3;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    check("sim_hold_data", {24'd0, bus_if.out_data}, 32'h55);
    bus_if.out_ready = 1'b1;
    send_bit(v[0]);
    check("sim_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check("sim_data", {24'd0, bus_if.out_data}, 32'hC3);
    check("sim_overrun", {31'd0, overrun}, 32'd0);
    idle_cycle();
    check("sim_drain_valid", {31'd0, bus_if.out_valid}, 32'd0);

    // RCT failure from a fresh start-up
    set_enable(1'b0);
    check("idle_online", {31'd0, online}, 32'd0);
    set_enable(1'b1);
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    check("rct_31_fail", {31'd0, rct_fail}, 32'd0);
    send_bit(1'b1);
    check("rct_32_fail", {31'd0, rct_fail}, 32'd1);
    check("rct_apt_clear", {31'd0, apt_fail}, 32'd0);
    check("rct_online", {31'd0, online}, 32'd0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("rct_no_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rct_sticky", {31'd0, rct_fail}, 32'd1);

    // Recovery
    pulse_clr();
    check("rec_rct_clear", {31'd0, rct_fail}, 32'd0);
    check("rec_online", {31'd0, online}, 32'd0);
    send_alt(1023);
    check("rec_1023_online", {31'd0, online}, 32'd0);
    send_bit(1'b1);
    check("rec_1024_online", {31'd0, online}, 32'd1);

    // APT failure: groups of 30 ones separated by single zeros
    set_enable(1'b0);
    set_enable(1'b1);
    for (int g = 0; g < 28; g++) begin
      for (int k = 0; k < 30; k++) begin
        if (g == 27 && k == 29) begin
          check("apt_839_fail", {31'd0, apt_fail}, 32'd0);
          send_bit(1'b1);
          check("apt_840_fail", {31'd0, apt_fail}, 32'd1);
          check("apt_rct_clear", {31'd0, rct_fail}, 32'd0);
          check("apt_online", {31'd0, online}, 32'd0);
        end else begin
          send_bit(1'b1);
        end
      end
      if (g < 27) send_bit(1'b0);
    end

    // Async reset mid-byte with a byte pending
    pulse_clr();
    check("apt_cleared", {31'd0, apt_fail}, 32'd0);
    send_alt(1024);
    check("rst2_online", {31'd0, online}, 32'd1);
    bus_if.out_ready = 1'b0;
    send_byte(8'hF0);
    check("rst2_valid", {31'd0, bus_if.out_valid}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("arst_data", {24'd0, bus_if.out_data}, 32'h00);
    check("arst_online", {31'd0, online}, 32'd0);
    check("arst_flags", {29'd0, rct_fail, apt_fail, overrun}, 32'd0);
    #10 rst_n = 1'b1;
    idle_cycle();
    check("post_rst_online", {31'd0, online}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
